// File: rtl/multi_pixel_frequency_manager.sv
`timescale 1ns/1ps
// multi_pixel_frequency_manager
// Samples up to CHANNELS configurable pixel positions of a line-scan stream
// against a runtime threshold. During an acquisition window (start..stop) it
// counts rising transitions of each channel's sampled bit and measures the
// window length in clocks. On stop, results are presented one register at a
// time on the register-write port, then irq is raised.
// Ports:
//   s00_axi_aclk / s00_axi_aresetn : clock, async active-low reset
//   pixel_data/pixel_valid/line_start : pixel stream
//   start/stop/clear               : acquisition control, irq acknowledge
//   cfg_we/cfg_channel/cfg_index   : per-channel pixel index write
//   threshold/threshold_we         : runtime threshold load
//   register_operation/number/write: register-bank write port (2 = write)
//   irq, busy                      : transfer complete, ACQUIRE/FLUSH active
module multi_pixel_frequency_manager #(
  parameter int unsigned CHANNELS          = 3,
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned INDEX_WIDTH       = 11,
  parameter int unsigned LINE_LENGTH       = 1040,
  parameter int unsigned INDEX_BASE        = 78,
  parameter int unsigned INDEX_STEP        = 448,
  parameter int unsigned COUNTER_WIDTH     = 32,
  parameter int unsigned WRITE_HOLD        = 4,
  parameter int unsigned DEFAULT_THRESHOLD = 20
) (
  input  logic                   s00_axi_aclk,
  input  logic                   s00_axi_aresetn,
  input  logic [DATA_WIDTH-1:0]  pixel_data,
  input  logic                   pixel_valid,
  input  logic                   line_start,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_channel,
  input  logic [INDEX_WIDTH-1:0] cfg_index,
  input  logic [DATA_WIDTH-1:0]  threshold,
  input  logic                   threshold_we,
  output logic [1:0]             register_operation,
  output logic [7:0]             register_number,
  output logic [31:0]            register_write,
  output logic                   irq,
  output logic                   busy
);

  localparam int unsigned NREGS = CHANNELS + 2;

  typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_FLUSH, S_DONE} state_t;

  state_t r_state, w_next;

  logic [DATA_WIDTH-1:0]    r_thr;
  logic [INDEX_WIDTH-1:0]   r_index [CHANNELS];
  logic [COUNTER_WIDTH-1:0] r_edge  [CHANNELS];
  logic [CHANNELS-1:0]      r_edge_sat;
  logic [CHANNELS-1:0]      r_sample;
  logic [COUNTER_WIDTH-1:0] r_window;
  logic                     r_win_sat;
  logic                     r_line_seen;
  logic [INDEX_WIDTH-1:0]   r_pix_cnt;
  logic [7:0]               r_reg_num;
  logic [15:0]              r_hold;
  logic                     r_irq;
  logic                     r_busy;

  logic                     w_enter_acq;
  logic                     w_pix_take;
  logic                     w_hit;
  logic                     w_last_beat;
  logic [INDEX_WIDTH-1:0]   w_pix_idx;
  logic [INDEX_WIDTH-1:0]   w_pix_next;
  logic [31:0]              w_status;
  logic [31:0]              w_wdata;

  assign w_enter_acq = start && (r_state == S_IDLE || r_state == S_DONE);
  // Pixels arriving on the stop edge are outside the window.
  assign w_pix_take  = (r_state == S_ACQUIRE) && !stop && pixel_valid;
  assign w_hit       = pixel_data > r_thr;
  assign w_pix_idx   = line_start ? '0 : r_pix_cnt;
  assign w_pix_next  = (w_pix_idx == INDEX_WIDTH'(LINE_LENGTH - 1)) ? '0 : w_pix_idx + 1'b1;
  assign w_last_beat = (r_hold == 16'(WRITE_HOLD - 1)) && (r_reg_num == 8'(NREGS));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_ACQUIRE;
      S_ACQUIRE: if (stop) w_next = S_FLUSH;
      S_FLUSH:   if (w_last_beat) w_next = S_DONE;
      S_DONE: begin
        if (start)      w_next = S_ACQUIRE;
        else if (clear) w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state <= S_IDLE;
      r_irq   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_irq   <= (w_next == S_DONE);
      r_busy  <= (w_next == S_ACQUIRE) || (w_next == S_FLUSH);
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_thr <= DATA_WIDTH'(DEFAULT_THRESHOLD);
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        r_index[k] <= INDEX_WIDTH'(INDEX_BASE + k * INDEX_STEP);
        r_edge[k]  <= '0;
      end
      r_edge_sat  <= '0;
      r_sample    <= '0;
      r_window    <= '0;
      r_win_sat   <= 1'b0;
      r_line_seen <= 1'b0;
      r_pix_cnt   <= '0;
      r_reg_num   <= '0;
      r_hold      <= '0;
    end else begin
      if (threshold_we) r_thr <= threshold;

      if (cfg_we && (r_state == S_IDLE || r_state == S_DONE)) begin
        for (int unsigned k = 0; k < CHANNELS; k++)
          if (cfg_channel == 4'(k)) r_index[k] <= cfg_index;
      end

      if (w_enter_acq) begin
        for (int unsigned k = 0; k < CHANNELS; k++) r_edge[k] <= '0;
        r_edge_sat  <= '0;
        r_sample    <= '0;
        r_window    <= '0;
        r_win_sat   <= 1'b0;
        r_line_seen <= 1'b0;
        r_pix_cnt   <= '0;
      end else if (r_state == S_ACQUIRE) begin
        // The window also counts the stop edge so it reads S-T.
        if (r_window == '1) r_win_sat <= 1'b1;
        else                r_window  <= r_window + 1'b1;

        if (w_pix_take) begin
          r_pix_cnt <= w_pix_next;
          if (line_start) r_line_seen <= 1'b1;
          for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (w_pix_idx == r_index[k]) begin
              r_sample[k] <= w_hit;
              if (w_hit && !r_sample[k]) begin
                if (r_edge[k] == '1) r_edge_sat[k] <= 1'b1;
                else                 r_edge[k]     <= r_edge[k] + 1'b1;
              end
            end
          end
        end

        if (stop) begin
          r_reg_num <= 8'd1;
          r_hold    <= '0;
        end
      end else if (r_state == S_FLUSH) begin
        if (r_hold == 16'(WRITE_HOLD - 1)) begin
          r_hold <= '0;
          if (!w_last_beat) r_reg_num <= r_reg_num + 8'd1;
        end else begin
          r_hold <= r_hold + 16'd1;
        end
      end
    end
  end

  always_comb begin
    w_status = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) w_status[k] = r_edge_sat[k];
    w_status[30] = r_line_seen;
    w_status[31] = r_win_sat;
  end

  always_comb begin
    w_wdata = '0;
    for (int unsigned k = 0; k < CHANNELS; k++)
      if (r_reg_num == 8'(k + 1)) w_wdata = 32'(r_edge[k]);
    if (r_reg_num == 8'(CHANNELS + 1)) w_wdata = 32'(r_window);
    if (r_reg_num == 8'(NREGS))        w_wdata = w_status;
  end

  assign register_operation = (r_state == S_FLUSH) ? 2'd2 : 2'd0;
  assign register_number    = (r_state == S_FLUSH) ? r_reg_num : '0;
  assign register_write     = (r_state == S_FLUSH) ? w_wdata : '0;
  assign irq                = r_irq;
  assign busy               = r_busy;

endmodule

// File: tb/tb_multi_pixel_frequency_manager.sv
`timescale 1ns/1ps
// Testbench: two instances (32-bit and 4-bit counters) share one stimulus
// stream; a count-based reference model predicts every output every cycle.
module tb_multi_pixel_frequency_manager;

  localparam int C  = 3;
  localparam int WH = 4;
  localparam int LL = 1040;
  localparam int NREGS = C + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pixel_data, threshold;
  logic        pixel_valid, line_start, start, stop, clear, cfg_we, threshold_we;
  logic [3:0]  cfg_channel;
  logic [10:0] cfg_index;
  logic [1:0]  op_a, op_b;
  logic [7:0]  num_a, num_b;
  logic [31:0] wr_a, wr_b;
  logic        irq_a, irq_b, busy_a, busy_b;

  always #5 clk = ~clk;

  multi_pixel_frequency_manager dut_a (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .line_start(line_start),
    .start(start), .stop(stop), .clear(clear),
    .cfg_we(cfg_we), .cfg_channel(cfg_channel), .cfg_index(cfg_index),
    .threshold(threshold), .threshold_we(threshold_we),
    .register_operation(op_a), .register_number(num_a), .register_write(wr_a),
    .irq(irq_a), .busy(busy_a));

  multi_pixel_frequency_manager #(.COUNTER_WIDTH(4)) dut_b (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .line_start(line_start),
    .start(start), .stop(stop), .clear(clear),
    .cfg_we(cfg_we), .cfg_channel(cfg_channel), .cfg_index(cfg_index),
    .threshold(threshold), .threshold_we(threshold_we),
    .register_operation(op_b), .register_number(num_b), .register_write(wr_b),
    .irq(irq_b), .busy(busy_b));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: true (unbounded) counts; saturation applied per instance.
  typedef enum {M_IDLE, M_ACQ, M_FLUSH, M_DONE} mstate_t;
  mstate_t m_st;
  int      m_thr, m_pos, m_win, m_fcnt;
  int      m_index [16];
  int      m_edges [16];
  bit      m_prev  [16];
  bit      m_line;

  task automatic model_reset();
    m_st = M_IDLE; m_thr = 20; m_pos = 0; m_win = 0; m_fcnt = 0; m_line = 0;
    for (int k = 0; k < 16; k++) begin
      m_index[k] = 78 + k * 448; m_edges[k] = 0; m_prev[k] = 0;
    end
  endtask

  task automatic model_enter();
    m_st = M_ACQ; m_win = 0; m_pos = 0; m_line = 0;
    for (int k = 0; k < 16; k++) begin m_edges[k] = 0; m_prev[k] = 0; end
  endtask

  task automatic model_cfg();
    if (cfg_we && int'(cfg_channel) < C) m_index[cfg_channel] = int'(cfg_index);
  endtask

  task automatic model_update();
    int idx;
    bit hit;
    case (m_st)
      M_IDLE: begin
        model_cfg();
        if (start) model_enter();
      end
      M_ACQ: begin
        m_win++;
        if (stop) begin
          m_st = M_FLUSH; m_fcnt = 0;
        end else if (pixel_valid) begin
          idx = line_start ? 0 : m_pos;
          if (line_start) m_line = 1;
          for (int k = 0; k < C; k++) begin
            if (idx == m_index[k]) begin
              hit = int'(pixel_data) > m_thr;
              if (hit && !m_prev[k]) m_edges[k]++;
              m_prev[k] = hit;
            end
          end
          m_pos = (idx == LL - 1) ? 0 : idx + 1;
        end
      end
      M_FLUSH: begin
        m_fcnt++;
        if (m_fcnt == NREGS * WH) m_st = M_DONE;
      end
      M_DONE: begin
        model_cfg();
        if (start) model_enter();
        else if (clear) m_st = M_IDLE;
      end
      default: m_st = M_IDLE;
    endcase
    if (threshold_we) m_thr = int'(threshold);
  endtask

  function automatic logic [31:0] exp_data(input int r, input int w);
    longint mx;
    logic [31:0] v;
    mx = (longint'(1) << w) - 1;
    v = '0;
    if (r >= 1 && r <= C)
      v = 32'((longint'(m_edges[r-1]) > mx) ? mx : longint'(m_edges[r-1]));
    else if (r == C + 1)
      v = 32'((longint'(m_win) > mx) ? mx : longint'(m_win));
    else if (r == C + 2) begin
      for (int k = 0; k < C; k++) v[k] = longint'(m_edges[k]) > mx;
      v[30] = m_line;
      v[31] = longint'(m_win) > mx;
    end
    return v;
  endfunction

  task automatic check_outputs();
    logic [1:0] e_op;
    logic [7:0] e_num;
    logic       e_busy, e_irq;
    int         r;
    e_busy = (m_st == M_ACQ) || (m_st == M_FLUSH);
    e_irq  = (m_st == M_DONE);
    r      = (m_st == M_FLUSH) ? m_fcnt / WH + 1 : 0;
    e_op   = (m_st == M_FLUSH) ? 2'd2 : 2'd0;
    e_num  = 8'(r);
    check("busy_a", 32'(busy_a), 32'(e_busy));
    check("busy_b", 32'(busy_b), 32'(e_busy));
    check("irq_a",  32'(irq_a),  32'(e_irq));
    check("irq_b",  32'(irq_b),  32'(e_irq));
    check("op_a",   32'(op_a),   32'(e_op));
    check("op_b",   32'(op_b),   32'(e_op));
    check("num_a",  32'(num_a),  32'(e_num));
    check("num_b",  32'(num_b),  32'(e_num));
    check("wr_a",   wr_a, (r == 0) ? 32'd0 : exp_data(r, 32));
    check("wr_b",   wr_b, (r == 0) ? 32'd0 : exp_data(r, 4));
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    start = 0; stop = 0; clear = 0; cfg_we = 0; threshold_we = 0;
    pixel_valid = 0; line_start = 0;
    check_outputs();
  endtask

  task automatic pix(input logic [7:0] d, input bit ls);
    pixel_valid = 1; pixel_data = d; line_start = ls;
    step();
  endtask

  task automatic cfg(input int ch, input int idx);
    cfg_we = 1; cfg_channel = 4'(ch); cfg_index = 11'(idx);
    step();
  endtask

  task automatic stop_and_flush();
    stop = 1; pixel_valid = 1; pixel_data = 8'd255; line_start = 1;
    step();
    repeat (NREGS * WH + 1) step();
  endtask

  task automatic async_reset();
    #2 rst_n = 0;
    model_reset();
    #1 check_outputs();
    @(posedge clk); #1 check_outputs();
    #3 rst_n = 1;
    step();
  endtask

  task automatic random_session(input int ncyc);
    for (int k = 0; k < C; k++) cfg(k, $urandom_range(0, 15));
    cfg($urandom_range(C, 15), $urandom_range(0, 15));
    start = 1; step();
    for (int i = 0; i < ncyc; i++) begin
      pixel_valid = ($urandom_range(0, 3) != 0);
      line_start  = ($urandom_range(0, 15) == 0);
      pixel_data  = 8'($urandom);
      if ($urandom_range(0, 63) == 0) begin threshold_we = 1; threshold = 8'($urandom); end
      if ($urandom_range(0, 31) == 0) start = 1;
      if ($urandom_range(0, 31) == 0) begin
        cfg_we = 1; cfg_channel = 4'($urandom_range(0, 2)); cfg_index = 11'($urandom_range(0, 15));
      end
      step();
    end
    stop_and_flush();
    if ($urandom_range(0, 1) == 1) begin clear = 1; step(); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    pixel_data = 0; threshold = 0; pixel_valid = 0; line_start = 0;
    start = 0; stop = 0; clear = 0; cfg_we = 0; threshold_we = 0;
    cfg_channel = 0; cfg_index = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_outputs();
    #3 rst_n = 1;
    step();

    // Empty window of 100 clocks.
    start = 1; step();
    repeat (99) step();
    stop_and_flush();

    // Channel 0 at default index 78 toggles across 10 lines.
    start = 1; step();
    for (int l = 0; l < 10; l++)
      for (int p = 0; p < LL; p++)
        pix((p == 78) ? ((l % 2 == 1) ? 8'd200 : 8'd0) : 8'($urandom_range(0, 20)), p == 0);
    stop_and_flush();

    // Threshold boundary and mid-window threshold change.
    clear = 1; step();
    cfg(0, 0);
    start = 1; step();
    pix(8'd20, 1); pix(8'd21, 1); pix(8'd20, 1); pix(8'd21, 1);
    threshold_we = 1; threshold = 8'd100; step();
    pix(8'd0, 1); pix(8'd50, 1); pix(8'd150, 1); pix(8'd50, 1);
    stop_and_flush();

    // 20 edges on channel 1 saturate the 4-bit instance.
    clear = 1; step();
    cfg(1, 0);
    start = 1; step();
    for (int i = 0; i < 40; i++) pix((i % 2 == 1) ? 8'd255 : 8'd0, 1);
    stop_and_flush();

    // Control corners.
    clear = 1; step();
    stop = 1; step();
    start = 1; stop = 1; step();
    cfg(2, 0);
    for (int i = 0; i < 6; i++) pix((i % 2 == 1) ? 8'd255 : 8'd0, 1);
    stop_and_flush();
    clear = 1; start = 1; step();
    pix(8'd255, 1);
    stop_and_flush();

    // Random sessions.
    for (int s = 0; s < 8; s++) random_session($urandom_range(50, 300));

    // Reset during FLUSH while register 2 is presented.
    if (m_st == M_DONE) begin clear = 1; step(); end
    start = 1; step();
    repeat (10) pix(8'($urandom), 1);
    stop = 1; step();
    repeat (WH + 1) step();
    check("mid_flush_num", 32'(num_a), 32'd2);
    async_reset();

    // Default indices restored: only positions 78/526/974 are bright.
    start = 1; step();
    for (int p = 0; p < LL; p++)
      pix((p == 78 || p == 526 || p == 974) ? 8'd255 : 8'd0, p == 0);
    stop_and_flush();
    clear = 1; step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
